// File: rtl/ras_stack.sv
// ras_stack: return-address stack for the frontend branch predictor.
// Calls push their link address and returns pop it. The top entry (entry 0)
// is presented combinationally as the predicted return target.
// Optional build macro RAS_STATS_EN adds count_o, overflow_o and underflow_o.
module ras_stack #(
    parameter int DEPTH = 2,
    parameter int VLEN  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [VLEN-1:0]             data_i,
    output logic                        ra_valid_o,
    output logic [VLEN-1:0]             ra_o
`ifdef RAS_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]  count_o,
    output logic                        overflow_o,
    output logic                        underflow_o
`endif
);

    // Decoded request after priority resolution (flush > swap > push > pop).
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_FLUSH = 3'd1,
        OP_SWAP  = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4
    } ras_op_e;

    ras_op_e         op_s;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [VLEN-1:0]  addr_q [DEPTH];
    logic [VLEN-1:0]  addr_d [DEPTH];

    // Resolve the request priority into a single operation.
    always_comb begin
        op_s = OP_NONE;
        if (flush_i) begin
            op_s = OP_FLUSH;
        end else if (push_i && pop_i) begin
            op_s = OP_SWAP;
        end else if (push_i) begin
            op_s = OP_PUSH;
        end else if (pop_i) begin
            op_s = OP_POP;
        end else begin
            op_s = OP_NONE;
        end
    end

    // Next state of the stack entries; shifts keep valid bits contiguous from the top.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        case (op_s)
            OP_FLUSH: begin
                // Addresses are left stale; only the valid bits matter.
                valid_d = {DEPTH{1'b0}};
            end
            OP_SWAP: begin
                // Coroutine call/return: replace the top, depth unchanged.
                valid_d[0] = 1'b1;
                addr_d[0]  = data_i;
            end
            OP_PUSH: begin
                // Shift down; the old bottom entry falls off silently.
                for (int i = 1; i < DEPTH; i++) begin
                    valid_d[i] = valid_q[i-1];
                    addr_d[i]  = addr_q[i-1];
                end
                valid_d[0] = 1'b1;
                addr_d[0]  = data_i;
            end
            OP_POP: begin
                // An empty stack must not change, so the shift is gated on the top.
                if (valid_q[0]) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        valid_d[i] = valid_q[i+1];
                        addr_d[i]  = addr_q[i+1];
                    end
                    valid_d[DEPTH-1] = 1'b0;
                    addr_d[DEPTH-1]  = {VLEN{1'b0}};
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    // Stack storage register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= {VLEN{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign ra_valid_o = valid_q[0];
    assign ra_o       = addr_q[0];

`ifdef RAS_STATS_EN
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          overflow_q;
    logic          overflow_d;
    logic          underflow_q;
    logic          underflow_d;

    // Occupancy counter and one-cycle overflow/underflow event pulses.
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        case (op_s)
            OP_FLUSH: begin
                count_d = CNT_ZERO;
            end
            OP_SWAP: begin
                // On an empty stack the swap acts as a plain push.
                if (count_q == CNT_ZERO) begin
                    count_d = CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end
            OP_PUSH: begin
                if (count_q == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            OP_POP: begin
                if (count_q == CNT_ZERO) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Statistics registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack (DEPTH=2, VLEN=32) with hand-computed results.
module tb_ras_stack;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        push_i;
    logic        pop_i;
    logic [31:0] data_i;
    logic        ra_valid_o;
    logic [31:0] ra_o;
`ifdef RAS_STATS_EN
    logic [1:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;
`endif

    int total_cnt;
    int bad_cnt;

    ras_stack #(.DEPTH(2), .VLEN(32)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .data_i     (data_i),
        .ra_valid_o (ra_valid_o),
        .ra_o       (ra_o)
`ifdef RAS_STATS_EN
        ,
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Apply one request for a single clock edge, then sample 1 ns after it.
    task automatic cyc(input logic f, input logic pu, input logic po, input logic [31:0] d);
        flush_i = f;
        push_i  = pu;
        pop_i   = po;
        data_i  = d;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        data_i  = 32'h0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        push_i  = 1'b0;
        pop_i   = 1'b0;
        data_i  = 32'h0;

        // Reset state
        #12;
        check("rst_valid", {31'd0, ra_valid_o}, 32'd0);
        check("rst_ra", ra_o, 32'h0);
`ifdef RAS_STATS_EN
        check("rst_count", {30'd0, count_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);
`endif
        rst_ni = 1'b1;
        #4;

        // Basic push/push/pop/pop
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0104);
        cyc(1'b0, 1'b1, 1'b0, 32'h8000_0208);
        check("p2_ra", ra_o, 32'h8000_0208);
        check("p2_valid", {31'd0, ra_valid_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("pop1_ra", ra_o, 32'h8000_0104);
        check("pop1_valid", {31'd0, ra_valid_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("pop2_valid", {31'd0, ra_valid_o}, 32'd0);

        // Overflow: A is lost
        cyc(1'b0, 1'b1, 1'b0, 32'h100);
        cyc(1'b0, 1'b1, 1'b0, 32'h200);
`ifdef RAS_STATS_EN
        check("ovf_pre", {31'd0, overflow_o}, 32'd0);
`endif
        cyc(1'b0, 1'b1, 1'b0, 32'h300);
        check("ovf_top", ra_o, 32'h300);
`ifdef RAS_STATS_EN
        check("ovf_pulse", {31'd0, overflow_o}, 32'd1);
        check("ovf_count", {30'd0, count_o}, 32'd2);
`endif
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("ovf_pop1", ra_o, 32'h200);
`ifdef RAS_STATS_EN
        check("ovf_end", {31'd0, overflow_o}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("ovf_pop2_valid", {31'd0, ra_valid_o}, 32'd0);

        // Simultaneous push & pop on a full stack
        cyc(1'b0, 1'b1, 1'b0, 32'h100);
        cyc(1'b0, 1'b1, 1'b0, 32'h200);
        cyc(1'b0, 1'b1, 1'b1, 32'h900);
        check("swap_top", ra_o, 32'h900);
`ifdef RAS_STATS_EN
        check("swap_count", {30'd0, count_o}, 32'd2);
        check("swap_no_ovf", {31'd0, overflow_o}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("swap_pop", ra_o, 32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("swap_empty", {31'd0, ra_valid_o}, 32'd0);

        // Push & pop on an empty stack acts as a push
        cyc(1'b0, 1'b1, 1'b1, 32'h700);
        check("swap0_top", ra_o, 32'h700);
        check("swap0_valid", {31'd0, ra_valid_o}, 32'd1);
`ifdef RAS_STATS_EN
        check("swap0_count", {30'd0, count_o}, 32'd1);
`endif
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("swap0_pop", {31'd0, ra_valid_o}, 32'd0);

        // Flush wins over push
        cyc(1'b0, 1'b1, 1'b0, 32'h100);
        cyc(1'b0, 1'b1, 1'b0, 32'h200);
        cyc(1'b1, 1'b1, 1'b0, 32'h500);
        check("flush_valid", {31'd0, ra_valid_o}, 32'd0);
`ifdef RAS_STATS_EN
        check("flush_count", {30'd0, count_o}, 32'd0);
        check("flush_no_ovf", {31'd0, overflow_o}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        check("flush_stays", {31'd0, ra_valid_o}, 32'd0);

        // Underflow on an empty stack
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("udf_valid", {31'd0, ra_valid_o}, 32'd0);
`ifdef RAS_STATS_EN
        check("udf_pulse", {31'd0, underflow_o}, 32'd1);
        check("udf_count", {30'd0, count_o}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
`ifdef RAS_STATS_EN
        check("udf_end", {31'd0, underflow_o}, 32'd0);
`endif
        cyc(1'b1, 1'b0, 1'b1, 32'h0);
`ifdef RAS_STATS_EN
        check("udf_flush_masked", {31'd0, underflow_o}, 32'd0);
`endif
        check("udf_flush_valid", {31'd0, ra_valid_o}, 32'd0);

        // Asynchronous reset mid-cycle, then first push sees an empty stack
        cyc(1'b0, 1'b1, 1'b0, 32'h123);
        cyc(1'b0, 1'b1, 1'b0, 32'h456);
        check("pre_arst_top", ra_o, 32'h456);
        #1;
        rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'd0, ra_valid_o}, 32'd0);
        check("arst_ra", ra_o, 32'h0);
`ifdef RAS_STATS_EN
        check("arst_count", {30'd0, count_o}, 32'd0);
`endif
        #2;
        rst_ni = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 32'h44);
        check("post_arst_top", ra_o, 32'h44);
        cyc(1'b0, 1'b0, 1'b1, 32'h0);
        check("post_arst_empty", {31'd0, ra_valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return-address stack for the frontend branch predictor.
- Sized by the RAS depth field of the active core configuration (2 entries in the 32-bit FPGA config).
- Predicts targets of function returns: pushes the link address on calls and pops on returns.
- Sits beside the BTB/BHT in the fetch stage and feeds the predicted return target to next-PC selection.

Parameters:
- DEPTH, 2, number of stack entries (≥1; taken from cva6_cfg RASDepth).
- VLEN, 32, width of a stored return address (equals XLEN for the sv32 config).

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  clear whole stack (mispredict/fence.i/exception).
- push_i  input  1  call decoded; store data_i as new top.
- pop_i  input  1  return decoded; discard current top.
- data_i  input  VLEN  return address to push (PC of call + 4).
- ra_valid_o  output  1  top entry holds a valid address.
- ra_o  output  VLEN  address held by the top entry.
- count_o  output  $clog2(DEPTH+1)  valid-entry count (only with RAS_STATS_EN).
- overflow_o  output  1  push dropped the bottom entry (only with RAS_STATS_EN).
- underflow_o  output  1  pop issued on empty stack (only with RAS_STATS_EN).

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-low on rst_ni.
- Storage: DEPTH entries of {valid, addr[VLEN-1:0]}. Entry 0 is the top.
- Reset: all valid=0 and all addr=0, so ra_valid_o=0 and ra_o=0. Stats outputs are 0.
- Read: ra_o/ra_valid_o are driven combinationally from entry 0, with zero latency. The pop consumer uses the value present in the same cycle pop_i is high.
- Updates are registered and visible on the cycle after the request edge.
- Priority: flush_i > (push_i & pop_i) > push_i > pop_i.
- flush_i: all valid cleared; addr left unchanged (don't-care). Any push/pop in the same cycle is ignored.
- push only: entries shift down (entry[i+1] ← entry[i]). Entry 0 ← {1, data_i}. Old entry[DEPTH-1] is discarded (overflow, silent).
- pop only: entries shift up (entry[i] ← entry[i+1]). Entry[DEPTH-1] ← {0, 0}. Pop on an empty stack leaves the state unchanged.
- push & pop same cycle (coroutine call/return): entry 0 ← {1, data_i} and all other entries are unchanged. Depth is unchanged.
- DEPTH=1: shifts degenerate. push writes entry 0; pop invalidates it.
- Valid bits are always contiguous from the top. No hole may appear.
- Reset asserted mid-operation: state clears immediately (asynchronously). The first push after rst_ni deassertion behaves as on an empty stack.
- No handshake back-pressure: every request is accepted in its cycle.

Optional Feature:
- Macro: RAS_STATS_EN.
- Defined:
  - count_o tracks valid entries, saturating at DEPTH and at 0.
  - flush sets count_o=0.
  - push&pop keeps count_o unchanged; if the stack is empty, push&pop behaves as a push and sets count_o=1.
  - overflow_o is a 1-cycle pulse, registered, on the cycle after a push-only at count=DEPTH.
  - underflow_o is a 1-cycle pulse on the cycle after a pop-only at count=0.
  - Neither pulse fires if flush_i was high in the same cycle.
- Undefined: the three ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset (DEPTH=2, VLEN=32): rst_ni low asynchronously mid-cycle → ra_valid_o=0 and ra_o=0 immediately. count_o=0 with RAS_STATS_EN.
- Push 0x8000_0104, then push 0x8000_0208 → ra_o=0x8000_0208 and valid=1. Pop → ra_o=0x8000_0104 and valid=1. Pop → valid=0.
- Overflow: push A=0x100, B=0x200, C=0x300 → top=0x300. Pop → top=0x200. Pop → valid=0 (A lost). overflow_o pulses once, one cycle after the C push.
- Simultaneous: stack holds {0x200, 0x100}; push_i=pop_i=1 with data_i=0x900 → top=0x900. Pop → top=0x100. count_o stays 2 during the swap.
- Flush priority: stack holds 2 entries; flush_i=push_i=1 with data_i=0x500 → next cycle valid=0 and count_o=0.
- Underflow: empty stack, pop_i=1 → state unchanged, ra_valid_o=0, underflow_o=1 for exactly one cycle.
